// File: rtl/enum_fold_ctrl.sv
// rtl/enum_fold_ctrl.sv - drains a bounded list producer and folds its elements into a signed sum.
// Optional ack watchdog enabled by defining ENUM_FOLD_TIMEOUT_EN.
module enum_fold_ctrl #(
    parameter int WIDTH       = 8,
    parameter int ACC_WIDTH   = 16,
    parameter int CNT_WIDTH   = 8
`ifdef ENUM_FOLD_TIMEOUT_EN
    ,
    parameter int ACK_TIMEOUT = 15
`endif
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic                 start_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [ACC_WIDTH-1:0] result_o,
    output logic [CNT_WIDTH-1:0] count_o,
    output logic                 error_o,
    output logic                 list_ready_o,
    output logic                 list_req_o,
    input  logic                 list_ack_i,
    input  logic                 list_eol_i,
    input  logic [WIDTH-1:0]     list_value_i
);

    typedef enum logic [2:0] {
        IDLE,
        PRIME,
        CHECK,
        WAIT_ACK,
        GAP,
        FINISH
    } state_t;

    state_t                 state_q, state_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   ready_q, ready_d;
    logic                   req_q, req_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [ACC_WIDTH-1:0]   result_q, result_d;
    logic [CNT_WIDTH-1:0]   count_q, count_d;
    logic [ACC_WIDTH-1:0]   value_ext;

`ifdef ENUM_FOLD_TIMEOUT_EN
    localparam int TMO_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
    logic [TMO_W-1:0]       tmo_q, tmo_d;
    logic                   err_q, err_d;
`endif

    assign value_ext = ACC_WIDTH'($signed(list_value_i));

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ready_q  <= 1'b0;
            req_q    <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            count_q  <= '0;
`ifdef ENUM_FOLD_TIMEOUT_EN
            tmo_q    <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
            req_q    <= req_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            count_q  <= count_d;
`ifdef ENUM_FOLD_TIMEOUT_EN
            tmo_q    <= tmo_d;
            err_q    <= err_d;
`endif
        end
    end

    // Outputs are loaded on the transition into a state so every port is a flop.
    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        ready_d  = ready_q;
        req_d    = req_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        count_d  = count_q;
`ifdef ENUM_FOLD_TIMEOUT_EN
        tmo_d    = tmo_q;
        err_d    = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = PRIME;
                    ready_d = 1'b1;
                    busy_d  = 1'b1;
                    acc_d   = '0;
                    cnt_d   = '0;
`ifdef ENUM_FOLD_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                end
            end
            PRIME: begin
                state_d = CHECK;
            end
            CHECK: begin
                if (list_eol_i) begin
                    state_d  = FINISH;
                    result_d = acc_q;
                    count_d  = cnt_q;
                    done_d   = 1'b1;
                end else begin
                    state_d = WAIT_ACK;
                    req_d   = 1'b1;
`ifdef ENUM_FOLD_TIMEOUT_EN
                    tmo_d   = '0;
`endif
                end
            end
            WAIT_ACK: begin
                if (list_ack_i) begin
                    state_d = GAP;
                    req_d   = 1'b0;
                    acc_d   = acc_q + value_ext;
                    cnt_d   = (cnt_q == {CNT_WIDTH{1'b1}}) ? cnt_q : cnt_q + CNT_WIDTH'(1);
                end
`ifdef ENUM_FOLD_TIMEOUT_EN
                else if (tmo_q == TMO_W'(ACK_TIMEOUT - 1)) begin
                    state_d  = FINISH;
                    req_d    = 1'b0;
                    result_d = acc_q;
                    count_d  = cnt_q;
                    done_d   = 1'b1;
                    err_d    = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
`endif
            end
            GAP: begin
                state_d = CHECK;
            end
            FINISH: begin
                state_d = IDLE;
                ready_d = 1'b0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign result_o     = result_q;
    assign count_o      = count_q;
    assign list_ready_o = ready_q;
    assign list_req_o   = req_q;
`ifdef ENUM_FOLD_TIMEOUT_EN
    assign error_o      = err_q;
`else
    assign error_o      = 1'b0;
`endif

endmodule

// File: doc/enum_fold_ctrl.md
Name: enum_fold_ctrl

Overview:
Sequencer that drains one bounded list producer over its ready/req/ack/eol interface and folds the elements into a signed running sum. It raises the producer's ready and issues one req edge per element. It accumulates each acked value and stops when eol is seen. The result, element count and completion pulse go back to the caller. It sits between a fold/sum call site and a BoundedEnum-style enumerator.

Parameters:
WIDTH, 8, width of the signed element value from the producer
ACC_WIDTH, 16, width of the signed accumulator and result
CNT_WIDTH, 8, width of the element counter
ACK_TIMEOUT, 15, max cycles spent in WAIT_ACK before abort (only with ENUM_FOLD_TIMEOUT_EN)

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  caller request; sampled only in IDLE
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse; result/count valid from this cycle on
result  out  ACC_WIDTH  signed sum of elements; held until next accepted start
count  out  CNT_WIDTH  number of elements folded; held like result
error  out  1  abort flag, valid with done (timeout build only, else 0)
list_ready  out  1  producer enable; low resets the producer
list_req  out  1  producer request; producer acts on its rising edge
list_ack  in  1  producer one-cycle ack; list_value valid while high
list_eol  in  1  producer end-of-list, valid while list_ready high
list_value  in  WIDTH  signed element

Behaviour:
- Reset (async, any state): state IDLE; busy, done, error, list_ready, list_req = 0; result, count, accumulator = 0.
- States: IDLE, PRIME, CHECK, WAIT_ACK, GAP, FINISH. All outputs are registered.
- IDLE:
  - start=1 -> PRIME.
  - Set list_ready=1, busy=1, clear accumulator, count, error.
  - result/count outputs keep their old values until FINISH.
- PRIME: one cycle so the producer sees ready high and initialises -> CHECK.
- CHECK:
  - list_eol=1 -> FINISH.
  - else list_req<=1 -> WAIT_ACK.
- WAIT_ACK:
  - Hold list_req=1 until list_ack=1.
  - On ack: accumulator += sign-extended list_value, wrap modulo 2^ACC_WIDTH.
  - count += 1, saturating at 2^CNT_WIDTH-1.
  - list_req<=0 -> GAP.
- GAP: one cycle with list_req=0 so the producer registers a low before the next edge -> CHECK.
- FINISH:
  - result<=accumulator, count output<=counter, done=1 for exactly this cycle.
  - list_ready<=0, busy<=0 -> IDLE.
- Latency, start sampled in cycle 0:
  - Empty list: done in cycle 3.
  - N elements with a producer that acks one cycle after the req edge: done in cycle 3+4N.
- Ignored inputs:
  - list_ack outside WAIT_ACK.
  - start outside IDLE.
  - list_eol outside CHECK.
- start held high through FINISH: a new run is accepted in the IDLE cycle that follows, so runs go back to back with a 1-cycle IDLE gap.
- Reset mid-run: list_ready and list_req drop asynchronously; no done pulse; result/count return to 0.
- list_req never rises in the same cycle list_ready rises. list_req is never high while list_ready is low.

Optional Feature:
ENUM_FOLD_TIMEOUT_EN
- Defined:
  - A counter clears on entry to WAIT_ACK and increments each cycle there without ack.
  - On reaching ACK_TIMEOUT -> FINISH with error=1, result = partial sum, count = elements so far.
  - Ack and timeout in the same cycle: ack wins.
- Undefined: no counter; WAIT_ACK waits indefinitely; error tied to 0.

Test Plan:
- Reset, then start with a mock producer giving eol=1 in CHECK -> done in cycle 3, result=0, count=0, error=0, list_req never high.
- Producer min=1, step=1, max=4 (values 1,2,3,4; eol after 4) -> done at cycle 19, result=10, count=4, exactly 4 list_req rising edges.
- Values -128,-128,-128 with ACC_WIDTH=8 build -> result wraps to -128 (0x80), count=3.
- Assert reset during the second WAIT_ACK -> list_ready/list_req/busy low immediately, result=0. A new start afterwards -> clean fresh run with correct sum.
- start held high across two runs of values {5} and {7} -> done pulses separated by one IDLE cycle, results 5 then 7. Spurious list_ack pulses injected in GAP/CHECK change nothing.
- ENUM_FOLD_TIMEOUT_EN, ACK_TIMEOUT=15, producer acks first element (value 9) then never again -> done with error=1, result=9, count=1, 15 cycles after second req rises.
